// File: rtl/messbauer_velocity_profile_generator_if.sv
// Control/status bundle of the Mossbauer velocity profile generator.
// The master drives run control and sweep configuration; the slave returns the DAC code and strobes.
interface messbauer_velocity_profile_generator_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int PERIOD_WIDTH = 16
);
  logic                    enable;
  logic                    mode;
  logic [DATA_WIDTH-1:0]   cfg_top;
  logic [PERIOD_WIDTH-1:0] cfg_period;
  logic [DATA_WIDTH-1:0]   cfg_reverse_step;
  logic [DATA_WIDTH-1:0]   out_value;
  logic                    dir;
  logic                    channel_strobe;
  logic                    sweep_start;
  logic                    busy;

  modport master (
    output enable, mode, cfg_top, cfg_period, cfg_reverse_step,
    input  out_value, dir, channel_strobe, sweep_start, busy
  );

  modport slave (
    input  enable, mode, cfg_top, cfg_period, cfg_reverse_step,
    output out_value, dir, channel_strobe, sweep_start, busy
  );
endinterface

// File: rtl/messbauer_velocity_profile_generator.sv
// Sawtooth/triangle velocity reference for the Mossbauer vibrator DAC, with
// per-channel and per-sweep strobes for the spectrum accumulator.
module messbauer_velocity_profile_generator #(
  parameter int DATA_WIDTH   = 12,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic clk,
  input  logic areset_n,
  messbauer_velocity_profile_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] counter;
  logic [PERIOD_WIDTH-1:0] period_l;
  logic [DATA_WIDTH-1:0]   top_l;
  logic [DATA_WIDTH-1:0]   step_l;
  logic                    mode_l;
  logic [DATA_WIDTH-1:0]   out_value;
  logic                    dir;
  logic                    channel_strobe;
  logic                    sweep_start;
  logic                    busy;

  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [DATA_WIDTH-1:0]   step_eff;
  logic                    channel_end;
  logic [DATA_WIDTH-1:0]   rev_from_top;
  logic [DATA_WIDTH-1:0]   rev_next;

  function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  // Zero period/step mean 1; triangle mode always returns one code per channel.
  assign period_eff   = (bus.cfg_period == '0) ? PERIOD_WIDTH'(1) : bus.cfg_period;
  assign step_eff     = (bus.mode || bus.cfg_reverse_step == '0) ? DATA_WIDTH'(1)
                                                                 : bus.cfg_reverse_step;
  assign channel_end  = (counter == period_l - PERIOD_WIDTH'(1));
  assign rev_from_top = sat_sub(top_l, step_l);
  assign rev_next     = sat_sub(out_value, step_l);

  // NOTE: every register here is sequential state, so it is written with <= only;
  // blocking assignments would let later lines in this block see half-updated values.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state          <= IDLE;
      counter        <= '0;
      period_l       <= PERIOD_WIDTH'(1);
      top_l          <= '0;
      step_l         <= DATA_WIDTH'(1);
      mode_l         <= 1'b0;
      out_value      <= '0;
      dir            <= 1'b0;
      channel_strobe <= 1'b0;
      sweep_start    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      channel_strobe <= 1'b0;
      sweep_start    <= 1'b0;
      case (state)
        IDLE: begin
          counter   <= '0;
          out_value <= '0;
          dir       <= 1'b0;
          if (bus.enable) begin
            state          <= FWD;
            period_l       <= period_eff;
            top_l          <= bus.cfg_top;
            step_l         <= step_eff;
            mode_l         <= bus.mode;
            busy           <= 1'b1;
            channel_strobe <= 1'b1;
            sweep_start    <= 1'b1;
          end
        end

        FWD: begin
          if (channel_end) begin
            counter <= '0;
            if (out_value != top_l) begin
              out_value      <= out_value + DATA_WIDTH'(1);
              channel_strobe <= 1'b1;
            end else begin
              state          <= REV;
              dir            <= 1'b1;
              out_value      <= rev_from_top;
              channel_strobe <= mode_l;
            end
          end else begin
            counter <= counter + PERIOD_WIDTH'(1);
          end
        end

        REV: begin
          if (channel_end) begin
            counter <= '0;
            if (out_value != '0) begin
              out_value      <= rev_next;
              channel_strobe <= mode_l;
            end else if (bus.enable) begin
              // Back-to-back sweep: relatch config so changes apply from this sweep on.
              state          <= FWD;
              dir            <= 1'b0;
              period_l       <= period_eff;
              top_l          <= bus.cfg_top;
              step_l         <= step_eff;
              mode_l         <= bus.mode;
              channel_strobe <= 1'b1;
              sweep_start    <= 1'b1;
            end else begin
              state <= IDLE;
              dir   <= 1'b0;
              busy  <= 1'b0;
            end
          end else begin
            counter <= counter + PERIOD_WIDTH'(1);
          end
        end

        default: begin
          state     <= IDLE;
          counter   <= '0;
          out_value <= '0;
          dir       <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_value      = out_value;
  assign bus.dir            = dir;
  assign bus.channel_strobe = channel_strobe;
  assign bus.sweep_start    = sweep_start;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_messbauer_velocity_profile_generator.sv
// Directed bench for the velocity profile generator: sawtooth, triangle,
// enable drop, config relatch, async reset and zero period/step handling.
module tb_messbauer_velocity_profile_generator;

  localparam int DW = 12;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic areset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  messbauer_velocity_profile_generator_if #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) bus ();

  messbauer_velocity_profile_generator #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  // Compare all outputs right now against the expected tuple.
  task automatic cmp(input string tag, input int v, input bit d, input bit cs,
                     input bit ss, input bit b);
    logic [DW+3:0] obs;
    logic [DW+3:0] expv;
    obs  = {bus.out_value, bus.dir, bus.channel_strobe, bus.sweep_start, bus.busy};
    expv = {DW'(v), d, cs, ss, b};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed value=%0d dir=%b cs=%b ss=%b busy=%b, expected value=%0d dir=%b cs=%b ss=%b busy=%b",
             tag, obs[DW+3:4], obs[3], obs[2], obs[1], obs[0], v, d, cs, ss, b);
    end
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic chk(input string tag, input int v, input bit d, input bit cs,
                     input bit ss, input bit b);
    @(negedge clk);
    cmp(tag, v, d, cs, ss, b);
  endtask

  // One channel of n clocks: strobes only on its first clock.
  task automatic chan(input string tag, input int v, input bit d, input bit cs,
                      input bit ss, input int n, input bit b = 1'b1);
    for (int i = 0; i < n; i++)
      chk(tag, v, d, (i == 0) ? cs : 1'b0, (i == 0) ? ss : 1'b0, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n             = 1'b0;
    bus.enable           = 1'b0;
    bus.mode             = 1'b0;
    bus.cfg_top          = '0;
    bus.cfg_period       = '0;
    bus.cfg_reverse_step = '0;
    @(negedge clk);
    @(negedge clk);
    cmp("reset", 0, 0, 0, 0, 0);
    areset_n = 1'b1;
    chk("idle_no_enable", 0, 0, 0, 0, 0);

    // Sawtooth top=7 period=4 step=4: 0..7, 3, 0 -> 40 clocks per sweep.
    bus.cfg_top = DW'(7); bus.cfg_period = PW'(4); bus.cfg_reverse_step = DW'(4);
    bus.enable = 1'b1;
    for (int s = 0; s < 2; s++) begin
      chan("saw_fwd0", 0, 0, 1, 1, 4);
      for (int v = 1; v <= 7; v++) chan("saw_fwd", v, 0, 1, 0, 4);
      chan("saw_rev3", 3, 1, 0, 0, 4);
      chan("saw_rev0", 0, 1, 0, 0, 4);
    end

    // Enable dropped at value 2: the sweep still completes, then IDLE.
    chan("drop_fwd0", 0, 0, 1, 1, 4);
    chan("drop_fwd1", 1, 0, 1, 0, 4);
    chk("drop_fwd2", 2, 0, 1, 0, 1);
    bus.enable = 1'b0;
    chan("drop_fwd2", 2, 0, 0, 0, 3);
    for (int v = 3; v <= 7; v++) chan("drop_fwd", v, 0, 1, 0, 4);
    chan("drop_rev3", 3, 1, 0, 0, 4);
    chan("drop_rev0", 0, 1, 0, 0, 4);
    chan("drop_idle", 0, 0, 0, 0, 6, 1'b0);

    // cfg_top 7->3 at value 4: this sweep reaches 7, the next tops at 3.
    bus.enable = 1'b1;
    for (int v = 0; v <= 3; v++) chan("top_fwd", v, 0, 1, (v == 0), 4);
    chk("top_fwd4", 4, 0, 1, 0, 1);
    bus.cfg_top = DW'(3);
    chan("top_fwd4", 4, 0, 0, 0, 3);
    for (int v = 5; v <= 7; v++) chan("top_fwd", v, 0, 1, 0, 4);
    chan("top_rev3", 3, 1, 0, 0, 4);
    chan("top_rev0", 0, 1, 0, 0, 4);
    for (int v = 0; v <= 3; v++) chan("top3_fwd", v, 0, 1, (v == 0), 4);
    bus.cfg_top = DW'(7);
    chan("top3_rev0", 0, 1, 0, 0, 4);

    // Async reset mid-channel at value 5.
    for (int v = 0; v <= 4; v++) chan("rst_fwd", v, 0, 1, (v == 0), 4);
    chk("rst_fwd5", 5, 0, 1, 0, 1);
    #2 areset_n = 1'b0;
    #1 cmp("rst_async", 0, 0, 0, 0, 0);
    bus.enable = 1'b0;
    chk("rst_held", 0, 0, 0, 0, 0);
    areset_n = 1'b1;
    chan("rst_idle", 0, 0, 0, 0, 2, 1'b0);

    // Triangle top=3 period=2 (step input ignored): 0,1,2,3,2,1,0 -> 14 clocks.
    bus.mode = 1'b1; bus.cfg_top = DW'(3); bus.cfg_period = PW'(2);
    bus.cfg_reverse_step = DW'(9);
    bus.enable = 1'b1;
    chan("tri_fwd0", 0, 0, 1, 1, 2);
    for (int v = 1; v <= 3; v++) chan("tri_fwd", v, 0, 1, 0, 2);
    for (int v = 2; v >= 0; v--) chan("tri_rev", v, 1, 1, 0, 2);
    chk("tri_fwd0b", 0, 0, 1, 1, 1);
    bus.enable = 1'b0;
    chan("tri_fwd0b", 0, 0, 0, 0, 1);
    for (int v = 1; v <= 3; v++) chan("tri_fwd", v, 0, 1, 0, 2);
    for (int v = 2; v >= 0; v--) chan("tri_rev", v, 1, 1, 0, 2);
    chan("tri_idle", 0, 0, 0, 0, 3, 1'b0);

    // period=0 and step=0 both act as 1: 0,1,2,1,0 one clock each.
    bus.mode = 1'b0; bus.cfg_top = DW'(2); bus.cfg_period = '0;
    bus.cfg_reverse_step = '0;
    bus.enable = 1'b1;
    chk("p0_c1", 0, 0, 1, 1, 1);
    chk("p0_c2", 1, 0, 1, 0, 1);
    chk("p0_c3", 2, 0, 1, 0, 1);
    chk("p0_c4", 1, 1, 0, 0, 1);
    chk("p0_c5", 0, 1, 0, 0, 1);
    chk("p0_c6", 0, 0, 1, 1, 1);
    bus.enable = 1'b0;
    chk("p0_c7", 1, 0, 1, 0, 1);
    chk("p0_c8", 2, 0, 1, 0, 1);
    chk("p0_c9", 1, 1, 0, 0, 1);
    chk("p0_c10", 0, 1, 0, 0, 1);
    chk("p0_idle", 0, 0, 0, 0, 0);

    // top=0: single forward value 0, one REV channel at 0, repeat.
    bus.cfg_top = '0; bus.cfg_period = PW'(1); bus.cfg_reverse_step = DW'(5);
    bus.enable = 1'b1;
    chk("t0_fwd", 0, 0, 1, 1, 1);
    chk("t0_rev", 0, 1, 0, 0, 1);
    chk("t0_fwd2", 0, 0, 1, 1, 1);
    bus.enable = 1'b0;
    chk("t0_rev2", 0, 1, 0, 0, 1);
    chk("t0_idle", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/messbauer_velocity_profile_generator.md
# messbauer_velocity_profile_generator

Parametrised, run-time configurable velocity reference generator for the Mössbauer test environment, driving the DAC code that sets the vibrator velocity. It produces either a sawtooth (slow forward, fast stepped return) or a symmetric triangle profile. Channel count, channel duration and return step are set per sweep. It also emits per-channel and per-sweep strobes for the spectrum accumulator and channel-address logic.

## Interface
- DATA_WIDTH, 12: width of out_value, cfg_top and cfg_reverse_step.
- PERIOD_WIDTH, 16: width of cfg_period and of the internal channel counter.

- clk  in  1  system clock; all state changes on its rising edge.
- areset_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- mode  in  1  0 = sawtooth, 1 = triangle.
- cfg_top  in  DATA_WIDTH  last forward channel value N; forward sweep is 0..N.
- cfg_period  in  PERIOD_WIDTH  clocks per channel; 0 is treated as 1.
- cfg_reverse_step  in  DATA_WIDTH  sawtooth return decrement per channel; 0 is treated as 1; ignored in triangle mode, where the step is 1.
- out_value  out  DATA_WIDTH  current channel code, registered.
- dir  out  1  0 = forward, 1 = reverse, registered.
- channel_strobe  out  1  one-clock pulse on the first clock of each counted channel.
- sweep_start  out  1  one-clock pulse on the first clock of each forward sweep.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, FWD, REV.
- The config registers top_l, period_l and step_l are latched from the cfg_* inputs and mode on every entry into FWD. This happens both on the IDLE->FWD transition and on the REV->FWD transition. Config changes at any other time have no effect.
- IDLE: out_value=0, dir=0, counter=0, busy=0. When enable=1, the block goes to FWD, latches config and sets out_value=0.
- Channel timing: the counter runs 0..period_l-1. At counter==period_l-1 the channel ends: the counter clears and the action for the current state applies. Every out_value is therefore held exactly period_l clocks.
- FWD, end of channel:
  - If out_value != top_l: out_value+1.
  - Else: enter REV, dir=1, out_value = sat(top_l - s), where s = step_l in sawtooth mode and 1 in triangle mode.
- REV, end of channel:
  - If out_value != 0: out_value = sat(out_value - s).
  - Else, if enable=1: enter FWD, dir=0, out_value stays 0, config is relatched.
  - Else, if enable=0: enter IDLE.
- sat(a-b) = (a > b) ? a-b : 0. Computed at DATA_WIDTH; out_value never wraps or underflows.
- enable is only examined in IDLE and at the end of the REV value-0 channel. Dropping enable mid-sweep lets the sweep finish back to 0 before the block goes IDLE.
- channel_strobe fires:
  - at the start of every FWD channel, in both modes;
  - at the start of every REV channel in triangle mode only.
  - It never fires in sawtooth REV.
- sweep_start fires together with channel_strobe on the first FWD channel, value 0.
- top_l=0: forward sweep is the single value 0, then one REV channel at 0, then repeat.

## Timing
- Reset: asynchronous. All outputs go to 0 immediately on areset_n low and stay 0 while it is low. State becomes IDLE and the counter clears. Reset mid-sweep aborts without completing the sweep.
- After areset_n rises, the first edge with enable=1 moves the block to FWD. The outputs updated at that edge are busy=1, sweep_start=1 and channel_strobe=1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Strobes are exactly one clock wide, including when period_l=1, where channel_strobe stays high on consecutive clocks.
- Sawtooth period = (top_l+1)·P + R·P clocks, where R is the number of REV values down to and including 0.
- Triangle period = (2·top_l+1)·P clocks (values 0..N..1 then 0 in REV).

## Test plan
- Reset: mid-run at out_value=5, pull areset_n low between clock edges -> all outputs 0 before the next edge; block stays IDLE until enable is seen.
- Sawtooth, top=7, period=4, step=4, enable held:
  - sequence 0..7 each 4 clk, then 3, then 0 (dir=1) each 4 clk;
  - period 40 clk;
  - sweep_start every 40 clk;
  - 8 channel_strobes per sweep.
- Triangle, top=3, period=2: sequence 0,1,2,3,2,1,0 each 2 clk, 14 clk period, 7 channel_strobes per sweep, dir=1 during 2,1,0.
- enable dropped during FWD at value 2 (top=7, sawtooth as above) -> sweep completes through 7,3,0; IDLE after the 0 channel; busy=0; no further sweep_start.
- cfg_top changed 7->3 at value 4 -> current sweep still reaches 7; next sweep tops at 3.
- cfg_period=0, cfg_reverse_step=0, top=2, sawtooth -> values 0,1,2,1,0 one clock each; channel_strobe high on the three FWD clocks; next sweep_start on clock 6.
